// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 32x32 register file: boot-loads all registers from an
// init table, then arbitrates CPU writeback (priority) against a buffered NPU stream.
module regfile_wr_sched #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_50,
  input  logic        rst,
  output logic [4:0]  init_addr,
  input  logic [31:0] init_data,
  output logic        init_done,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_wr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_stall,
  input  logic        npu_valid,
  input  logic [4:0]  npu_wr,
  input  logic [31:0] npu_wd,
  output logic        npu_ready,
  output logic        WE,
  output logic [4:0]  WR,
  output logic [31:0] WD
);

  // Handshakes: an NPU request transfers on any cycle with npu_valid && npu_ready and
  // must be held stable until then; the CPU holds cpu_we/cpu_wr/cpu_wd while cpu_stall=1.

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic [4:0]       fifo_wr [FIFO_DEPTH];
  logic [31:0]      fifo_wd [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve;

  logic fifo_empty;
  logic fifo_full;
  logic starve_hit;
  logic cpu_grant;
  logic fifo_grant;
  logic push;
  logic pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign starve_hit = !fifo_empty && (starve == STV_W'(STARVE_LIMIT));
  assign push       = npu_valid && npu_ready;
  assign pop        = fifo_grant;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  // rst is folded in here so the stall/ready outputs are already safe during the reset cycle.
  always_comb begin
    next_state = state;
    cpu_stall  = 1'b1;
    npu_ready  = 1'b0;
    cpu_grant  = 1'b0;
    fifo_grant = 1'b0;
    if (rst) begin
      next_state = ST_INIT;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_addr == 5'd31) begin
            next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          cpu_stall  = starve_hit;
          npu_ready  = !fifo_full;
          cpu_grant  = cpu_we && !starve_hit;
          fifo_grant = !cpu_grant && !fifo_empty;
        end
        default: begin
          next_state = ST_INIT;
        end
      endcase
    end
  end

  // Register-file write port; writes to r0 are dropped by holding WE low.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      WE        <= 1'b0;
      WR        <= 5'd0;
      WD        <= 32'd0;
      init_addr <= 5'd0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      WE        <= 1'b1;
      WR        <= init_addr;
      WD        <= init_data;
      init_addr <= init_addr + 5'd1;
      if (init_addr == 5'd31) begin
        init_done <= 1'b1;
      end
    end else begin
      WE <= 1'b0;
      if (cpu_grant) begin
        WE <= (cpu_wr != 5'd0);
        WR <= cpu_wr;
        WD <= cpu_wd;
      end else if (fifo_grant) begin
        WE <= (fifo_wr[rd_ptr] != 5'd0);
        WR <= fifo_wr[rd_ptr];
        WD <= fifo_wd[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk_50) begin
    if (push) begin
      fifo_wr[wr_ptr] <= npu_wr;
      fifo_wd[wr_ptr] <= npu_wd;
    end
  end

  // Counts CPU wins over a waiting NPU entry; at the limit the head is forced through.
  always_ff @(posedge clk_50) begin
    if (rst || pop || fifo_empty) begin
      starve <= '0;
    end else if (cpu_grant) begin
      starve <= starve + STV_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Bench for regfile_wr_sched: directed boot/contention/full/reset scenarios plus random
// traffic, all checked against a queue-based reference model every cycle.
module tb_regfile_wr_sched;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic [4:0]  init_addr;
  logic [31:0] init_data;
  logic        init_done;
  logic        cpu_we;
  logic [4:0]  cpu_wr;
  logic [31:0] cpu_wd;
  logic        cpu_stall;
  logic        npu_valid;
  logic [4:0]  npu_wr;
  logic [31:0] npu_wd;
  logic        npu_ready;
  logic        WE;
  logic [4:0]  WR;
  logic [31:0] WD;

  logic [31:0] init_tab [32];
  assign init_data = init_tab[init_addr];

  always #10 clk_50 = ~clk_50;

  regfile_wr_sched #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_50   (clk_50),
    .rst      (rst),
    .init_addr(init_addr),
    .init_data(init_data),
    .init_done(init_done),
    .cpu_we   (cpu_we),
    .cpu_wr   (cpu_wr),
    .cpu_wd   (cpu_wd),
    .cpu_stall(cpu_stall),
    .npu_valid(npu_valid),
    .npu_wr   (npu_wr),
    .npu_wd   (npu_wd),
    .npu_ready(npu_ready),
    .WE       (WE),
    .WR       (WR),
    .WD       (WD)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: boot index, pending NPU requests, starvation run length.
  bit          m_run;
  bit          m_done;
  int          m_idx;
  int          m_starve;
  logic [36:0] m_q [$];
  logic [36:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_run    = 1'b0;
    m_done   = 1'b0;
    m_idx    = 0;
    m_starve = 0;
    m_q.delete();
    exp_q.delete();
  endtask

  task automatic fill_tab(input bit rnd);
    for (int i = 0; i < 32; i++) begin
      init_tab[i] = rnd ? $urandom : (32'h100 + 32'(i));
    end
  endtask

  task automatic drive(input logic r, input logic cw, input logic [4:0] cr, input logic [31:0] cd,
                       input logic nv, input logic [4:0] nr, input logic [31:0] nd);
    rst       = r;
    cpu_we    = cw;
    cpu_wr    = cr;
    cpu_wd    = cd;
    npu_valid = nv;
    npu_wr    = nr;
    npu_wd    = nd;
    #1;
  endtask

  // Check this cycle's outputs, advance the model across the clock edge, then move to the next cycle.
  task automatic step();
    logic        stall_e;
    logic        ready_e;
    logic        nonempty;
    logic        cpu_g;
    logic        granted;
    logic        popped;
    logic        accept;
    logic [36:0] g;
    logic [36:0] e;
    stall_e = rst || !m_run || (m_q.size() != 0 && m_starve == STARVE_LIMIT);
    ready_e = !rst && m_run && (m_q.size() < FIFO_DEPTH);
    check("cpu_stall", 32'(cpu_stall), 32'(stall_e));
    check("npu_ready", 32'(npu_ready), 32'(ready_e));
    check("init_done", 32'(init_done), 32'(m_done));
    check("init_addr", 32'(init_addr), 32'(m_idx));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("we", 32'(WE), 32'd1);
      if (WE === 1'b1) begin
        check("wr", 32'(WR), 32'(e[36:32]));
        check("wd", WD, e[31:0]);
      end
    end else begin
      check("we_idle", 32'(WE), 32'd0);
    end

    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      exp_q.push_back({5'(m_idx), init_tab[m_idx]});
      if (m_idx == 31) begin
        m_run  = 1'b1;
        m_done = 1'b1;
      end
      m_idx = (m_idx + 1) % 32;
    end else begin
      nonempty = (m_q.size() != 0);
      accept   = npu_valid && ready_e;
      cpu_g    = cpu_we && !stall_e;
      granted  = 1'b0;
      popped   = 1'b0;
      g        = '0;
      if (cpu_g) begin
        g       = {cpu_wr, cpu_wd};
        granted = 1'b1;
      end else if (nonempty) begin
        g       = m_q.pop_front();
        granted = 1'b1;
        popped  = 1'b1;
      end
      if (popped || !nonempty) m_starve = 0;
      else if (cpu_g) m_starve++;
      if (granted && g[36:32] != 5'd0) exp_q.push_back(g);
      if (accept) m_q.push_back({npu_wr, npu_wd});
    end
    @(posedge clk_50);
    @(negedge clk_50);
  endtask

  logic        hw;
  logic [4:0]  hr;
  logic [31:0] hd;
  logic        nv;
  logic [4:0]  nr;
  logic [31:0] nd;
  logic        r;
  logic        cpu_hold;
  logic        npu_hold;
  int          ni;

  initial begin
    fill_tab(1'b0);
    rst = 1'b1; cpu_we = 1'b0; cpu_wr = '0; cpu_wd = '0;
    npu_valid = 1'b0; npu_wr = '0; npu_wd = '0;
    @(posedge clk_50);
    @(negedge clk_50);
    model_reset();

    // Reset cycle, then the boot load from 0x100+i.
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 33; k++) begin
      drive(0, (k > 20), 5'd2, 32'h2222_2222, 0, 0, 0);
      if (k == 32) check("boot_done_cycle32", 32'(init_done), 32'd1);
      step();
    end

    // Plain CPU write, then a dropped r0 write and an NPU push to r0.
    drive(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("cpu_write_wd", WD, 32'hDEADBEEF);
    step();
    drive(0, 1, 5'd0, 32'h1234_5678, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 5'd0, 32'hAAAA_0000);
    check("r0_cpu_dropped", 32'(WE), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
    end

    // Contention: NPU (7,0x77) pushed at t=k0 under continuous CPU writes to r3.
    for (int k = 0; k < 9; k++) begin
      drive(0, 1, 5'd3, 32'h3333_3333, (k == 0), 5'd7, 32'h77);
      if (k == 5) check("contention_stall_t5", 32'(cpu_stall), 32'd1);
      if (k == 6) check("contention_npu_wr_t6", 32'(WR), 32'd7);
      step();
    end

    // FIFO full: three back-to-back NPU requests while the CPU stays busy.
    ni = 0;
    for (int k = 0; k < 18; k++) begin
      drive(0, 1, 5'd9, 32'h9999_9999, (ni < 3), 5'(10 + ni), 32'hA0 + 32'(ni));
      if (k == 2) check("fifo_full_third_blocked", 32'(npu_ready), 32'd0);
      if (npu_valid && npu_ready) ni++;
      step();
    end
    check("fifo_full_all_accepted", 32'(ni), 32'd3);
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
    end

    // Reset mid-operation with two NPU entries pending; boot repeats with a new table.
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 5'd12, 32'hC0C0_C0C0, 1, 5'(20 + k), 32'hBAD0 + 32'(k));
      step();
    end
    fill_tab(1'b1);
    drive(1, 1, 5'd12, 32'hC0C0_C0C0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("midreset_init_addr", 32'(init_addr), 32'd0);
    step();
    for (int k = 0; k < 34; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
    end

    // Random traffic honouring both hold rules, with occasional resets.
    cpu_hold = 1'b0;
    npu_hold = 1'b0;
    hw = 0; hr = 0; hd = 0; nv = 0; nr = 0; nd = 0;
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 299) == 0);
      if (!cpu_hold) begin
        hw = ($urandom_range(0, 99) < 60);
        hr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        hd = $urandom;
      end
      if (!npu_hold) begin
        nv = ($urandom_range(0, 99) < 45);
        nr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        nd = $urandom;
      end
      if (r) fill_tab(1'b1);
      drive(r, hw, hr, hd, nv, nr, nd);
      cpu_hold = !r && cpu_we && cpu_stall;
      npu_hold = !r && npu_valid && !npu_ready;
      step();
    end
    for (int k = 0; k < 40; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_sched.md
# regfile_wr_sched

Write-port scheduler for the 32x32 register file. It owns the file's single write port (WE/WR/WD). After reset it first runs a boot sequence that loads all 32 registers from an external init table. It then arbitrates each cycle between CPU writeback, which has priority, and NPU result writeback, which is buffered in a small FIFO and protected by a starvation guard. It sits between the CPU writeback stage, the NPU result path and the register file.

## Interface
Parameters:
- FIFO_DEPTH, 2, NPU write-request buffer entries (power of two, >=2)
- STARVE_LIMIT, 4, consecutive CPU grants tolerated while the NPU FIFO is non-empty

Ports:
- clk_50  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- init_addr  out  5  index into the init table during the boot sequence
- init_data  in  32  init table value for init_addr (combinational, same cycle)
- init_done  out  1  boot load complete
- cpu_we  in  1  CPU writeback request
- cpu_wr  in  5  CPU destination register
- cpu_wd  in  32  CPU write data
- cpu_stall  out  1  CPU write not accepted this cycle; CPU holds cpu_we/cpu_wr/cpu_wd
- npu_valid  in  1  NPU write request
- npu_wr  in  5  NPU destination register
- npu_wd  in  32  NPU write data
- npu_ready  out  1  NPU request accepted when npu_valid && npu_ready
- WE  out  1  register file write enable (registered)
- WR  out  5  register file write address (registered)
- WD  out  32  register file write data (registered)

## Operation
- States: INIT and RUN. rst forces INIT from any state.
- On a cycle with rst high, the following are cleared:
  - init_addr=0, WE=0, WR=0, WD=0
  - init_done=0, FIFO count=0, starve counter=0
  - cpu_stall=1, npu_ready=0 (both combinational, see below)
- INIT:
  - Each cycle, capture (init_addr, init_data) as the next write, then increment init_addr.
  - After init_addr=31 is captured, go to RUN.
  - Address 0 is written like any other register in INIT.
  - cpu_stall=1 and npu_ready=0 throughout INIT.
- RUN arbitration, decided once per cycle:
  1. cpu_we && !cpu_stall: grant CPU.
  2. Else, FIFO non-empty: grant the FIFO head and pop it.
  3. Else: no write.
- Granted writes with address 0 are dropped: WE=0 next cycle. A dropped NPU entry is still popped.
- npu_ready = (state==RUN) && (count<FIFO_DEPTH). There is no bypass: a pushed entry becomes eligible the cycle after it is pushed.
- Push and pop in the same cycle are allowed when not full; count is unchanged.
- Starvation guard:
  - The counter increments on each cycle the CPU is granted while the FIFO is non-empty.
  - It clears when the FIFO pops or is empty.
  - cpu_stall = (state==INIT) || (FIFO non-empty && counter==STARVE_LIMIT).
  - In a stall cycle, the FIFO head is granted.
- WE/WR/WD are registered from the grant: one write per cycle at most, and WE is never asserted otherwise.
- init_done is registered, set on entering RUN, cleared only by rst.

## Timing
- Grant-to-register-file latency is 1 cycle.
- NPU accept-to-WE latency is at least 2 cycles.
- Reset release is cycle 0.
  - Init writes appear on WE/WR in cycles 1..32 with WR=0..31.
  - In cycle 32, init_done=1 and cpu_stall=0 (if no starvation).
  - A CPU write presented in cycle 32 appears on WE in cycle 33.
- Starvation timing, with the NPU entry pushed at cycle t under continuous CPU writes:
  - CPU is granted in cycles t+1..t+4.
  - cpu_stall=1 in cycle t+5 only.
  - The NPU write appears on WE in cycle t+6.
- Reset mid-operation:
  - WE=0 in the cycle after rst is sampled.
  - Any pending FIFO entries are discarded and are never written.
  - INIT restarts at address 0.

## Test plan
- Boot load: init_data=0x100+init_addr, release rst -> WE=1 for cycles 1..32, WR=0..31, WD=0x100..0x11F; init_done=1 at cycle 32.
- CPU write: cpu_we=1, cpu_wr=5, cpu_wd=0xDEADBEEF in RUN -> next cycle WE=1, WR=5, WD=0xDEADBEEF; cpu_stall=0.
- Zero register: cpu_wr=0 -> next cycle WE=0. Then npu push to register 0 -> entry popped, WE stays 0, FIFO empty.
- Contention: NPU pushes (7, 0x77) at cycle t while the CPU writes register 3 every cycle -> WR=3 in cycles t+2..t+5, cpu_stall=1 at t+5, WR=7 / WD=0x77 at t+6, CPU resumes at t+6.
- FIFO full: CPU busy, NPU presents 3 requests back-to-back -> first 2 accepted, npu_ready=0 on the 3rd until the first pop.
- Reset mid-op: rst asserted for one cycle with 2 FIFO entries pending -> next cycle WE=0, init_addr=0, init_done=0; no NPU data is ever written, and the boot sequence repeats.
